// File: rtl/score_if.sv
// Game-controller to score-keeper bundle: controller status and pickup pulse in,
// BCD score/high-score digits and update strobes out to the HUD.
interface score_if;
    logic [2:0]  game_state;
    logic        game_en;
    logic        game_reset;
    logic        bonus;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic        new_high;
    logic        score_tick;

    modport master (
        output game_state, game_en, game_reset, bonus,
        input  score_bcd, high_bcd, new_high, score_tick
    );

    modport slave (
        input  game_state, game_en, game_reset, bonus,
        output score_bcd, high_bcd, new_high, score_tick
    );
endinterface

// File: rtl/score_ctl.sv
// Survival/bonus score accumulator (saturating 4-digit BCD) with game-over high-score latch.
// Define SCORE_HIGHSCORE_EN to build the high-score register; otherwise high_bcd/new_high are tied low.
module score_ctl #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int BONUS_PTS = 10
) (
    input  logic clk,
    input  logic hard_reset_n,
    score_if.slave bus
);

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TC   = PW'(TICK_DIV - 1);
    localparam logic [15:0]    BONUS_BCD  = to_bcd(BONUS_PTS);
    localparam logic [15:0]    BONUS1_BCD = to_bcd(BONUS_PTS + 1);
    localparam logic [2:0]     ST_PLAYING = 3'b010;
    localparam logic [2:0]     ST_OVER    = 3'b100;

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   score_q, score_d;
    logic          score_tick_q, score_tick_d;

    logic          active;
    logic          tick;
    logic          take_bonus;
    logic [15:0]   addend;
    logic [15:0]   sum;
    logic [15:0]   sat_sum;
    logic [4:0]    dsum;
    logic          carry;

    always_comb begin
        active     = (bus.game_state == ST_PLAYING) && bus.game_en;
        tick       = active && (presc_q == PRESC_TC);
        take_bonus = active && bus.bonus;

        unique case ({tick, take_bonus})
            2'b01:   addend = BONUS_BCD;
            2'b10:   addend = 16'h0001;
            2'b11:   addend = BONUS1_BCD;
            default: addend = 16'h0000;
        endcase

        // Digit-serial decimal add; a carry out of the thousands digit means > 9999.
        sum   = '0;
        dsum  = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'b0, carry};
            if (dsum > 5'd9) begin
                sum[4*i +: 4] = 4'(dsum - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = dsum[3:0];
                carry         = 1'b0;
            end
        end
        sat_sum = carry ? 16'h9999 : sum;

        presc_d = presc_q;
        score_d = score_q;
        if (bus.game_reset) begin
            presc_d = '0;
            score_d = '0;
        end else if (active) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            score_d = sat_sum;
        end
        score_tick_d = (score_d != score_q);
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            presc_q      <= '0;
            score_q      <= '0;
            score_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            score_q      <= score_d;
            score_tick_q <= score_tick_d;
        end
    end

    assign bus.score_bcd  = score_q;
    assign bus.score_tick = score_tick_q;

`ifdef SCORE_HIGHSCORE_EN
    logic [2:0]  state_q, state_d;
    logic        over_q, over_d;
    logic [15:0] high_q, high_d;
    logic        new_high_q, new_high_d;

    // over_q marks the cycle after game_state first reads gameover; the compare happens then.
    always_comb begin
        state_d    = bus.game_state;
        over_d     = (bus.game_state == ST_OVER) && (state_q != ST_OVER);
        high_d     = high_q;
        new_high_d = new_high_q;
        if (over_q && (score_q > high_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
        if (bus.game_reset) begin
            new_high_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q    <= 3'b000;
            over_q     <= 1'b0;
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            over_q     <= over_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    assign bus.high_bcd = high_q;
    assign bus.new_high = new_high_q;
`else
    assign bus.high_bcd = 16'h0000;
    assign bus.new_high = 1'b0;
`endif

endmodule

// File: doc/score_ctl.md
# score_ctl

Score and high-score keeper sitting directly downstream of the game controller. It consumes the controller's `game_state`, `game_en` and `game_reset` outputs, accumulates a survival score in BCD while the game is in the playing state, and adds bonus points on pickup events. At game over it compares the score against a stored high score. It drives BCD digits to the on-screen text/HUD renderer.

## Interface
- `TICK_DIV`, default 10_000_000: clock cycles per survival point (0.1 s at 100 MHz); legal range ≥ 2.
- `BONUS_PTS`, default 10: points added per `bonus` pulse; legal range 0–99.
- `clk` input 1: system clock.
- `hard_reset_n` input 1: asynchronous, active-low reset.
- `game_state` input 3: controller state; encodings are init=000, idle=001, playing=010, hit=011, gameover=100.
- `game_en` input 1: controller game-enable level.
- `game_reset` input 1: one-cycle pulse that starts a new game.
- `bonus` input 1: one-cycle pickup pulse from the collision/pickup logic.
- `score_bcd` output 16: current score, 4 BCD digits, with [15:12] as the thousands digit.
- `high_bcd` output 16: high score, 4 BCD digits.
- `new_high` output 1: level, high when the last finished game set a new high score.
- `score_tick` output 1: one-cycle pulse each time the score changes.

## Operation
- The block is active when `game_state == 010` and `game_en == 1`. Only in that condition does the prescaler count and `bonus` get accepted.
- Prescaler:
  - Counts 0 to TICK_DIV-1 while the block is active.
  - At terminal count it wraps to 0 and raises an internal tick.
  - In the hit state and all other states it holds its value; it does not clear.
- Score update in each active cycle:
  - Increment = (tick ? 1 : 0) + (bonus ? BONUS_PTS : 0).
  - A simultaneous tick and bonus add 1 + BONUS_PTS in one cycle.
  - The increment is applied as BCD addition with decimal carry across all 4 digits.
  - The score saturates at 9999: if the true sum exceeds 9999, the result is 9999. Saturation never wraps.
- `score_tick` is asserted in the cycle the score register changes. It is not asserted when the score is saturated at 9999 and unchanged.
- `game_reset` pulse:
  - Clears the score, the prescaler and `new_high` in the next cycle.
  - It has priority over a same-cycle tick or bonus.
  - `high_bcd` is not affected.
- Game-over detection:
  - A registered copy of `game_state` detects the transition into 100 from any other state.
  - On that edge, compare `score_bcd > high_bcd` (BCD magnitude, equivalent to an unsigned compare of the 16-bit vectors).
  - If greater: `high_bcd <= score_bcd` and `new_high <= 1`.
  - If equal or less: both are unchanged.
- `new_high` stays high until the next `game_reset` or reset.
- A `bonus` pulse outside the active condition is dropped; it is not queued.

## Timing
- All outputs are registered.
- Reset values: `score_bcd = 0000`, `high_bcd = 0000`, `new_high = 0`, `score_tick = 0`, prescaler = 0, previous-state register = 000.
- Tick latency: the score changes on the clock edge after the cycle where the prescaler is at TICK_DIV-1.
- Bonus latency: the score changes on the edge after `bonus` is sampled high. `score_tick` is coincident with the new score value.
- High-score latency: `high_bcd` and `new_high` update 2 edges after `game_state` first reads 100. One edge registers the previous state and one performs the compare.
- Reset mid-game: an asynchronous clear of every register, including the high score.

## Configuration
- `SCORE_HIGHSCORE_EN`:
  - Defined: high-score register, compare logic and previous-state register are implemented as described.
  - Not defined: that logic is omitted, `high_bcd` is tied to 16'h0000 and `new_high` is tied to 0. Score accumulation is unchanged.

## Test plan
- TICK_DIV=4, state=010, en=1 for 40 cycles, starting from score 0000 → `score_bcd` = 0010, with `score_tick` pulsing every 4th cycle.
- Score 0009, `bonus` (BONUS_PTS=10) in the same cycle as a tick → score 0020 the next cycle, with exactly one `score_tick` pulse.
- Score 9995, `bonus` → 9999; a further tick → score stays 9999 and no `score_tick` is asserted.
- State 010 → 011 for 20 cycles → 010 with TICK_DIV=4 → no score change during 011, and the prescaler resumes from its held value.
- Score 0123, high 0100, state → 100 → `high_bcd` = 0123 and `new_high` = 1 after 2 edges. Then a `game_reset` pulse → score 0000, `new_high` = 0, high stays 0123. A later game ending at 0050 leaves high at 0123.
- `bonus` while state=001 or en=0 → no change. `hard_reset_n` low mid-game → all outputs at 0 asynchronously. With the macro undefined, `high_bcd` and `new_high` stay 0 through a game-over.
